// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and the
// instruction memory (slave).
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_wait;

  modport master (output imem_addr, output imem_req, input imem_rdata, input imem_wait);
  modport slave  (input imem_addr, input imem_req, output imem_rdata, output imem_wait);
endinterface

// File: rtl/fetch_stage.sv
// mMIPS instruction-fetch stage: PC, next-PC select, imem handshake,
// one-entry hold buffer, IF/ID register and a saturating fetch-stall counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_write,
  input  logic                   ifid_write,
  input  logic                   imem_en,
  input  logic                   pipe_en,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  fetch_stage_if.master          imem,
  output logic [31:0]            ifid_instr,
  output logic [31:0]            ifid_pc4,
  output logic                   ifid_valid,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_p0, pc_d;
  logic [31:0]            hold_instr_p0, hold_instr_d;
  logic [31:0]            hold_pc4_p0, hold_pc4_d;
  logic [31:0]            ifid_instr_p1, ifid_instr_d;
  logic [31:0]            ifid_pc4_p1, ifid_pc4_d;
  logic                   vld_p1, vld_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   adv, done, flush;
  logic [31:0]            pc_plus4;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Request is also gated by rst so it drops the instant reset asserts mid-wait.
  assign imem.imem_req  = rst & imem_en & (state_q == FETCH);
  assign imem.imem_addr = pc_p0;

  assign adv      = pipe_en & ifid_write;
  assign done     = imem.imem_req & ~imem.imem_wait;
  assign flush    = pipe_en & branch_taken;
  assign pc_plus4 = pc_p0 + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_p0;
    hold_instr_d = hold_instr_p0;
    hold_pc4_d   = hold_pc4_p0;
    ifid_instr_d = ifid_instr_p1;
    ifid_pc4_d   = ifid_pc4_p1;
    vld_d        = vld_p1;
    if (flush) begin
      pc_d         = branch_target;
      state_d      = FETCH;
      ifid_instr_d = NOP_WORD;
      ifid_pc4_d   = branch_target;
      vld_d        = 1'b0;
    end else if (pipe_en) begin
      if (pc_write) pc_d = pc_plus4;
      unique case (state_q)
        FETCH: begin
          if (done && adv) begin
            ifid_instr_d = imem.imem_rdata;
            ifid_pc4_d   = pc_plus4;
            vld_d        = 1'b1;
          end else if (done) begin
            hold_instr_d = imem.imem_rdata;
            hold_pc4_d   = pc_plus4;
            state_d      = HOLD;
          end else if (adv) begin
            ifid_instr_d = NOP_WORD;
            ifid_pc4_d   = pc_plus4;
            vld_d        = 1'b0;
          end
        end
        HOLD: begin
          if (adv) begin
            ifid_instr_d = hold_instr_p0;
            ifid_pc4_d   = hold_pc4_p0;
            vld_d        = 1'b1;
            state_d      = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Stage p0 -> p1: PC, hold buffer, IF/ID register and stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      pc_p0         <= RESET_PC;
      hold_instr_p0 <= '0;
      hold_pc4_p0   <= '0;
      ifid_instr_p1 <= NOP_WORD;
      ifid_pc4_p1   <= '0;
      vld_p1        <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_p0         <= pc_d;
      hold_instr_p0 <= hold_instr_d;
      hold_pc4_p0   <= hold_pc4_d;
      ifid_instr_p1 <= ifid_instr_d;
      ifid_pc4_p1   <= ifid_pc4_d;
      vld_p1        <= vld_d;
      if (imem.imem_req && imem.imem_wait) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign ifid_instr = ifid_instr_p1;
  assign ifid_pc4   = ifid_pc4_p1;
  assign ifid_valid = vld_p1;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps plus random traffic,
// checked against a transaction-level model of the fetch rules.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, pc_write, ifid_write, imem_en, pipe_en, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [15:0] stall_cnt;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(NOP), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
    .imem_en(imem_en), .pipe_en(pipe_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus.master),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: architectural PC, IF/ID contents, and an optional parked word.
  logic [31:0] m_pc, m_instr, m_pc4, m_buf_instr, m_buf_pc4;
  logic        m_valid, m_parked;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_req();
    return rst && imem_en && !m_parked;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    m_parked = 1'b0; m_buf_instr = 32'h0; m_buf_pc4 = 32'h0; m_cnt = 0;
  endtask

  task automatic model_clock();
    logic got;
    logic [31:0] seq;
    if (!rst) begin model_reset(); return; end
    got = m_req() && !bus.imem_wait;
    if (m_req() && bus.imem_wait && m_cnt < 65535) m_cnt++;
    if (!pipe_en) return;
    seq = m_pc + 32'd4;
    if (branch_taken) begin
      m_pc = branch_target; m_parked = 1'b0;
      m_instr = NOP; m_pc4 = branch_target; m_valid = 1'b0;
      return;
    end
    if (pc_write) m_pc = seq;
    if (m_parked) begin
      if (ifid_write) begin
        m_instr = m_buf_instr; m_pc4 = m_buf_pc4; m_valid = 1'b1; m_parked = 1'b0;
      end
    end else if (got) begin
      if (ifid_write) begin m_instr = bus.imem_rdata; m_pc4 = seq; m_valid = 1'b1; end
      else begin m_buf_instr = bus.imem_rdata; m_buf_pc4 = seq; m_parked = 1'b1; end
    end else if (ifid_write) begin
      m_instr = NOP; m_pc4 = seq; m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_req()});
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("stall_cnt", {16'b0, stall_cnt}, m_cnt[31:0]);
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(input logic pe, input logic pw, input logic iw, input logic ie,
                       input logic bt, input logic [31:0] tgt, input logic wt,
                       input logic [31:0] rd);
    pipe_en = pe; pc_write = pw; ifid_write = iw; imem_en = ie;
    branch_taken = bt; branch_target = tgt; bus.imem_wait = wt; bus.imem_rdata = rd;
  endtask

  logic [31:0] frz_instr, frz_pc;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    model_reset();
    tick();
    tick();
    chk("reset_instr", ifid_instr, NOP);
    chk("reset_valid", {31'b0, ifid_valid}, 32'h0);
    rst = 1'b1;

    // Straight-line fetch of three words
    drive(1, 1, 1, 1, 0, 32'h0, 0, 32'h8C01_0004); tick();
    drive(1, 1, 1, 1, 0, 32'h0, 0, 32'h0022_1820); tick();
    drive(1, 1, 1, 1, 0, 32'h0, 0, 32'h1000_FFFF); tick();
    chk("seq_instr", ifid_instr, 32'h1000_FFFF);
    chk("seq_pc4", ifid_pc4, 32'hC);
    chk("seq_addr", bus.imem_addr, 32'hC);
    drive(1, 1, 1, 1, 0, 32'h0, 0, 32'h0000_0001); tick();

    // Memory wait at PC 0x10
    repeat (3) begin drive(1, 0, 1, 1, 0, 32'h0, 1, 32'hDEAD_BEEF); tick(); end
    chk("wait_addr", bus.imem_addr, 32'h10);
    chk("wait_valid", {31'b0, ifid_valid}, 32'h0);
    chk("wait_cnt", {16'b0, stall_cnt}, 32'd3);
    drive(1, 1, 1, 1, 0, 32'h0, 0, 32'h1234_5678); tick();
    chk("wait_word", ifid_instr, 32'h1234_5678);

    // Load-use stall: word parked in the hold buffer
    drive(1, 1, 0, 1, 0, 32'h0, 0, 32'hAC02_0008); tick();
    #1 chk("hold_req", {31'b0, bus.imem_req}, 32'h0);
    repeat (2) begin drive(1, 0, 0, 1, 0, 32'h0, 0, 32'h0); tick(); end
    drive(1, 0, 1, 1, 0, 32'h0, 0, 32'h0); tick();
    chk("hold_release", ifid_instr, 32'hAC02_0008);
    chk("hold_valid", {31'b0, ifid_valid}, 32'h1);

    // Branch while parked
    drive(1, 1, 0, 1, 0, 32'h0, 0, 32'h1111_2222); tick();
    drive(1, 1, 1, 1, 1, 32'h40, 0, 32'h3333_4444); tick();
    chk("flush_addr", bus.imem_addr, 32'h40);
    chk("flush_instr", ifid_instr, NOP);
    chk("flush_pc4", ifid_pc4, 32'h40);

    // PC wrap and pipeline freeze
    drive(1, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0); tick();
    drive(1, 1, 1, 1, 0, 32'h0, 0, 32'h5555_6666); tick();
    chk("wrap_addr", bus.imem_addr, 32'h0);
    frz_instr = m_instr; frz_pc = m_pc;
    repeat (2) begin drive(0, 1, 1, 1, 1, 32'h80, 0, 32'h7777_8888); tick(); end
    chk("freeze_instr", ifid_instr, frz_instr);
    chk("freeze_pc", bus.imem_addr, frz_pc);

    // Random traffic
    repeat (400) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0, {$urandom, 2'b00} >> 2 << 2,
            $urandom_range(0, 2) == 0, $urandom);
      tick();
    end

    // Counter saturation, then reset mid-wait
    drive(1, 0, 1, 1, 0, 32'h0, 1, 32'h0);
    if (m_parked) begin drive(1, 0, 1, 1, 1, 32'h100, 1, 32'h0); tick(); end
    drive(1, 0, 1, 1, 0, 32'h0, 1, 32'h0);
    repeat (65540) tick();
    chk("sat_cnt", {16'b0, stall_cnt}, 32'h0000_FFFF);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
